// File: rtl/univ_cnt_seq_pkg.sv
// Shared opcodes and state encoding for the universal-counter command sequencer.
// Revision: 1.0
`default_nettype none

package univ_cnt_seq_pkg;

   localparam logic [1:0] OP_COUNT_UP = 2'b00;
   localparam logic [1:0] OP_COUNT_DN = 2'b01;
   localparam logic [1:0] OP_LOAD     = 2'b10;
   localparam logic [1:0] OP_CLR      = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_LOAD = 3'd2,
      S_CLR  = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/univ_cnt_seq_timer.sv
// N-bit loadable down-counter that flags the final cycle (remaining == 1) of a RUN window.
// Revision: 1.0
`default_nettype none

module univ_cnt_seq_timer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] start_val,
   input  logic         dec,
   output logic         last
);

   logic [N-1:0] rem;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem <= '0;
      end else if (start) begin
         rem <= start_val;
      end else if (dec && (rem != '0)) begin
         rem <= rem - N'(1);
      end
   end

   assign last = (rem == N'(1));

endmodule

`default_nettype wire

// File: rtl/univ_cnt_seq.sv
// Command sequencer driving a universal binary counter with exact cycle counts.
// Optional macro UNIV_CNT_SEQ_STOP_AT_LIMIT_EN stops counting at all-ones/zero. Revision: 1.0
`default_nettype none

module univ_cnt_seq
   import univ_cnt_seq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_arg,
   output logic         syn_clr,
   output logic         load,
   output logic         en,
   output logic         up,
   output logic [N-1:0] d,
   input  logic [N-1:0] q,
   output logic         busy,
   output logic         done,
   output logic         sat
);

   state_t state;
   logic   en_reg;
   logic   last;
   logic   limit;
   logic   accept;
   logic   is_count;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign is_count  = (cmd_op == OP_COUNT_UP) || (cmd_op == OP_COUNT_DN);

`ifdef UNIV_CNT_SEQ_STOP_AT_LIMIT_EN
   assign limit = (state == S_RUN) && (up ? (q == '1) : (q == '0));
`else
   logic unused_q;
   assign unused_q = ^q;
   assign limit    = 1'b0;
`endif

   // Masking with the limit keeps the counter from wrapping while the FSM catches up.
   assign en = en_reg & ~limit;

   univ_cnt_seq_timer #(.N(N)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && is_count),
      .start_val (cmd_arg),
      .dec       (state == S_RUN),
      .last      (last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         en_reg  <= 1'b0;
         up      <= 1'b0;
         load    <= 1'b0;
         syn_clr <= 1'b0;
         done    <= 1'b0;
         sat     <= 1'b0;
         d       <= '0;
      end else begin
         load    <= 1'b0;
         syn_clr <= 1'b0;
         done    <= 1'b0;
         sat     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_count) begin
                     if (cmd_arg == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state  <= S_RUN;
                        en_reg <= 1'b1;
                        up     <= (cmd_op == OP_COUNT_UP);
                     end
                  end else if (cmd_op == OP_LOAD) begin
                     state <= S_LOAD;
                     load  <= 1'b1;
                     d     <= cmd_arg;
                  end else begin
                     state   <= S_CLR;
                     syn_clr <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (limit || last) begin
                  state  <= S_DONE;
                  en_reg <= 1'b0;
                  up     <= 1'b0;
                  done   <= 1'b1;
                  sat    <= limit;
               end
            end
            S_LOAD, S_CLR: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_univ_cnt_seq.sv
// Self-checking bench for univ_cnt_seq with a behavioural counter and arithmetic reference model.
// Revision: 1.0
`default_nettype none

module tb_univ_cnt_seq;
   import univ_cnt_seq_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [N-1:0] cmd_arg = '0;
   logic         syn_clr, load, en, up, busy, done, sat;
   logic [N-1:0] d;
   logic [N-1:0] q;

   int checks = 0;
   int failures = 0;
   logic [N-1:0] ref_q = '0;

   univ_cnt_seq #(.N(N)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .syn_clr(syn_clr), .load(load),
      .en(en), .up(up), .d(d), .q(q), .busy(busy), .done(done), .sat(sat)
   );

   always #5 clk = ~clk;

   // The counter being operated.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       q <= '0;
      else if (syn_clr) q <= '0;
      else if (load)    q <= d;
      else if (en)      q <= up ? q + 8'd1 : q - 8'd1;
   end

   task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] arg, input int inject);
      int exp_en, exp_done, exp_load, exp_clr, lim_dist;
      logic exp_sat;
      logic [N-1:0] exp_q;
      int n_en, n_load, n_clr, cyc, w;
      logic bad_up, bad_excl, bad_hs, bad_d, got_done, got_sat;
      exp_en = 0; exp_load = 0; exp_clr = 0; exp_sat = 1'b0; exp_done = 2;
      exp_q = ref_q;
      if (op == OP_COUNT_UP || op == OP_COUNT_DN) begin
         lim_dist = (op == OP_COUNT_UP) ? 255 - int'(ref_q) : int'(ref_q);
         exp_en = int'(arg); exp_done = int'(arg) + 1;
`ifdef UNIV_CNT_SEQ_STOP_AT_LIMIT_EN
         if (lim_dist < int'(arg)) begin
            exp_en = lim_dist; exp_done = lim_dist + 2; exp_sat = 1'b1;
         end
`endif
         exp_q = (op == OP_COUNT_UP) ? ref_q + N'(exp_en) : ref_q - N'(exp_en);
      end else if (op == OP_LOAD) begin
         exp_load = 1; exp_q = arg;
      end else begin
         exp_clr = 1; exp_q = '0;
      end

      @(negedge clk);
      w = 0;
      while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1; n_en = 0; n_load = 0; n_clr = 0;
      bad_up = 0; bad_excl = 0; bad_hs = 0; bad_d = 0; got_done = 0; got_sat = 0;
      while (cyc <= 300) begin
         if (inject != 0 && cyc == inject) begin
            cmd_valid = 1'b1; cmd_op = OP_CLR; cmd_arg = N'($urandom);
         end else if (inject != 0 && cyc == inject + 1) begin
            cmd_valid = 1'b0;
         end
         if (en) begin
            n_en++;
            if (up !== (op == OP_COUNT_UP)) bad_up = 1;
         end
         if (load) begin
            n_load++;
            if (d !== arg || cyc != 1) bad_d = 1;
         end
         if (syn_clr) begin
            n_clr++;
            if (cyc != 1) bad_d = 1;
         end
         if (int'(syn_clr) + int'(load) + int'(en) > 1) bad_excl = 1;
         if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_hs = 1;
         if (done === 1'b1) begin got_done = 1; got_sat = sat; break; end
         @(negedge clk); cyc++;
      end
      cmd_valid = 1'b0;

      checks++;
      if (!got_done) begin
         failures++; $display("FAIL done_timeout op=%0d arg=%0d got=none want=cycle %0d", op, arg, exp_done);
      end else if (cyc != exp_done) begin
         failures++; $display("FAIL done_cycle op=%0d arg=%0d got=%0d want=%0d", op, arg, cyc, exp_done);
      end
      checks++;
      if (n_en != exp_en || n_load != exp_load || n_clr != exp_clr) begin
         failures++;
         $display("FAIL pulse_counts op=%0d arg=%0d got en=%0d load=%0d clr=%0d want en=%0d load=%0d clr=%0d",
                  op, arg, n_en, n_load, n_clr, exp_en, exp_load, exp_clr);
      end
      checks++;
      if (bad_up || bad_excl || bad_hs || bad_d) begin
         failures++;
         $display("FAIL control_shape op=%0d arg=%0d got up_err=%0d excl_err=%0d hs_err=%0d d_err=%0d want all 0",
                  op, arg, bad_up, bad_excl, bad_hs, bad_d);
      end
      checks++;
      if (got_sat !== exp_sat) begin
         failures++; $display("FAIL sat op=%0d arg=%0d got=%0b want=%0b", op, arg, got_sat, exp_sat);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || q !== exp_q) begin
         failures++;
         $display("FAIL after_cmd op=%0d arg=%0d got ready=%0b busy=%0b q=%0h want ready=1 busy=0 q=%0h",
                  op, arg, cmd_ready, busy, q, exp_q);
      end
      ref_q = exp_q;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({syn_clr, load, en, up, done, sat, busy} !== 7'b0 || d !== '0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state got ctl=%b d=%0h ready=%0b want ctl=0000000 d=0 ready=1",
                  {syn_clr, load, en, up, done, sat, busy}, d, cmd_ready);
      end
      ref_q = '0;
   endtask

   task automatic test_count();
      run_cmd(OP_COUNT_UP, 8'd12, 0);
      checks++;
      if (q !== 8'd12) begin failures++; $display("FAIL count_up_12 got q=%0d want 12", q); end
      run_cmd(OP_COUNT_DN, 8'd6, 0);
      checks++;
      if (q !== 8'd6) begin failures++; $display("FAIL count_dn_6 got q=%0d want 6", q); end
   endtask

   task automatic test_load_clr();
      run_cmd(OP_LOAD, 8'h03, 0);
      run_cmd(OP_COUNT_UP, 8'd2, 0);
      checks++;
      if (q !== 8'd5) begin failures++; $display("FAIL load_then_up got q=%0d want 5", q); end
      run_cmd(OP_CLR, 8'h5A, 0);
      checks++;
      if (q !== 8'd0) begin failures++; $display("FAIL clr got q=%0d want 0", q); end
   endtask

   task automatic test_zero_arg();
      run_cmd(OP_COUNT_UP, 8'd0, 0);
      run_cmd(OP_COUNT_DN, 8'd0, 0);
   endtask

   task automatic test_busy_ignore();
      run_cmd(OP_COUNT_UP, 8'd8, 3);
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic seen;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_COUNT_UP; cmd_arg = 8'd3;
      @(posedge clk);
      cyc = 0; seen = 0;
      while (cyc < 20 && !seen) begin
         @(negedge clk); cyc++;
         if (done === 1'b1) begin
            seen = 1; cmd_op = OP_LOAD; cmd_arg = 8'hA5;
         end
      end
      checks++;
      if (!seen || cyc != 4) begin failures++; $display("FAIL b2b_first_done got cycle=%0d want 4", cyc); end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b want 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (load !== 1'b1 || d !== 8'hA5) begin
         failures++; $display("FAIL b2b_second_accept got load=%0b d=%0h want load=1 d=a5", load, d);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (q !== 8'hA5 || cmd_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_final got q=%0h ready=%0b want q=a5 ready=1", q, cmd_ready);
      end
      ref_q = 8'hA5;
   endtask

   task automatic test_limit();
      run_cmd(OP_LOAD, 8'hFD, 0);
      run_cmd(OP_COUNT_UP, 8'd10, 0);
      checks++;
`ifdef UNIV_CNT_SEQ_STOP_AT_LIMIT_EN
      if (q !== 8'hFF) begin failures++; $display("FAIL limit_q got=%0h want ff", q); end
`else
      if (q !== 8'h07) begin failures++; $display("FAIL limit_q got=%0h want 07", q); end
`endif
      run_cmd(OP_LOAD, 8'h02, 0);
      run_cmd(OP_COUNT_DN, 8'd5, 0);
   endtask

   task automatic test_max_count();
      run_cmd(OP_CLR, 8'h00, 0);
      run_cmd(OP_COUNT_UP, 8'hFF, 0);
   endtask

   task automatic test_random();
      logic [1:0] op;
      logic [N-1:0] arg;
      for (int i = 0; i < 25; i++) begin
         op  = 2'($urandom_range(0, 3));
         arg = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 255)) : N'($urandom_range(0, 20));
         if (op == OP_LOAD && $urandom_range(0, 1) == 1) arg = N'($urandom_range(250, 255));
         run_cmd(op, arg, 0);
      end
   endtask

   task automatic test_reset_mid_run();
      logic bad;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_COUNT_UP; cmd_arg = 8'd50;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL reset_mid_run got en=%0b busy=%0b done=%0b want 0 0 0", en, busy, done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (done !== 1'b0 || en !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL no_done_after_reset got done_or_en=1 want 0"); end
      ref_q = '0;
   endtask

   initial begin
      test_reset();
      test_count();
      test_load_clr();
      test_zero_arg();
      test_busy_ignore();
      test_back_to_back();
      test_limit();
      test_max_count();
      test_random();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
